// File: rtl/aes_inv_pkg.sv
// ============================================================================
// Module  : aes_inv_pkg
// Brief   : Shared constants for the AES-128 inverse cipher: controller state
//           codes, default sizes and the key-schedule round constant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_inv_pkg;

    localparam int NR_DEF = 10;
    localparam int KW_DEF = 128;

    // Controller state codes, shared with the inverse-cipher controller
    localparam logic [2:0] RES = 3'd0;
    localparam logic [2:0] STL = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] SHI = 3'd4;
    localparam logic [2:0] MIX = 3'd5;
    localparam logic [2:0] INV = 3'd6;
    localparam logic [2:0] FIN = 3'd7;

    function automatic logic [7:0] rcon(input logic [3:0] k);
        logic [7:0] r;
        case (k)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_key_sched_sbox.sv
// ============================================================================
// Module  : aes_sbox
// Brief   : Combinational AES forward S-box, 256-entry lookup table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] c_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        y = c_SBOX[a];
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// ============================================================================
// Module  : aes_inv_key_sched
// Brief   : AES-128 inverse-cipher round-key generator/store. Expands the key
//           forward during controller pre-roll, then replays keys 10..0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_inv_key_sched
    import aes_inv_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic [2:0]    cs,
    input  logic [7:0]    cot,
    input  logic [KW-1:0] key_in,
    output logic [KW-1:0] rkey,
    output logic [3:0]    rk_idx,
    output logic          key_rdy
);

    localparam logic [7:0] c_NR8  = 8'(NR);
    localparam logic [7:0] c_2NR8 = 8'(2 * NR);

    logic [KW-1:0] r_key_mem [0:NR];

    logic          w_exp_en;
    logic [7:0]    w_cot_p1;
    logic [NR:0]   w_wr_sel;
    logic [KW-1:0] w_src;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [31:0]   w_t;
    logic [31:0]   w_w0, w_w1, w_w2, w_w3;
    logic [KW-1:0] w_next_key;
    logic [7:0]    w_rd_idx8;
    logic          w_rd_hit;
    logic [KW-1:0] w_rd_key;

    assign w_exp_en = ((cs == STL) || (cs == INV)) && (cot < c_NR8);
    assign w_cot_p1 = cot + 8'd1;

    // One-hot write decode of cot+1; entry 0 also captures the raw key on cot==0
    always_comb begin
        w_wr_sel    = '0;
        w_wr_sel[0] = w_exp_en && (cot == 8'd0);
        for (int i = 1; i <= NR; i++) begin
            w_wr_sel[i] = w_exp_en && (w_cot_p1 == 8'(i));
        end
    end

    always_comb begin
        w_src = key_in;
        for (int i = 1; i < NR; i++) begin
            if (cot == 8'(i)) begin
                w_src = r_key_mem[i];
            end
        end
    end

    assign w_rot = {w_src[23:0], w_src[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (w_rot[8*g +: 8]),
            .y (w_sub[8*g +: 8])
        );
    end

    assign w_t        = w_sub ^ {rcon(w_cot_p1[3:0]), 24'h000000};
    assign w_w0       = w_src[127:96] ^ w_t;
    assign w_w1       = w_src[95:64]  ^ w_w0;
    assign w_w2       = w_src[63:32]  ^ w_w1;
    assign w_w3       = w_src[31:0]   ^ w_w2;
    assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i <= NR; i++) begin
                r_key_mem[i] <= '0;
            end
        end else begin
            if (w_wr_sel[0]) begin
                r_key_mem[0] <= key_in;
            end
            for (int i = 1; i <= NR; i++) begin
                if (w_wr_sel[i]) begin
                    r_key_mem[i] <= w_next_key;
                end
            end
        end
    end

    // 2*NR-cot wraps above NR whenever cot > 2*NR, so one compare covers both ends
    assign w_rd_idx8 = c_2NR8 - cot;
    assign w_rd_hit  = key_rdy && (cot >= c_NR8) && (w_rd_idx8 <= c_NR8);

    always_comb begin
        w_rd_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (w_rd_idx8 == 8'(i)) begin
                w_rd_key = r_key_mem[i];
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rkey    <= '0;
            rk_idx  <= '0;
            key_rdy <= 1'b0;
        end else begin
            rkey   <= w_rd_hit ? w_rd_key : '0;
            rk_idx <= w_rd_hit ? w_rd_idx8[3:0] : 4'd0;
            if (w_exp_en && (cot == c_NR8 - 8'd1)) begin
                key_rdy <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
// ============================================================================
// Module  : tb_aes_inv_key_sched
// Brief   : Scoreboard bench for aes_inv_key_sched with an independent
//           GF(2^8)-derived key-expansion reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_inv_key_sched;

    localparam logic [2:0] c_RES = 3'd0, c_STL = 3'd1, c_ADD = 3'd2, c_SUB = 3'd3;
    localparam logic [2:0] c_SHI = 3'd4, c_MIX = 3'd5, c_INV = 3'd6, c_FIN = 3'd7;

    localparam logic [127:0] c_KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_KEY_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] c_KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic [2:0]   cs  = 3'd0;
    logic [7:0]   cot = 8'd0;
    logic [127:0] key_in = '0;
    logic [127:0] rkey;
    logic [3:0]   rk_idx;
    logic         key_rdy;

    aes_inv_key_sched dut (
        .clk     (clk),
        .res     (res),
        .cs      (cs),
        .cot     (cot),
        .key_in  (key_in),
        .rkey    (rkey),
        .rk_idx  (rk_idx),
        .key_rdy (key_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] rkey;
        logic [3:0]   idx;
        logic         rdy;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   m_sbox [256];
    logic [7:0]   m_rcon [11];
    logic [127:0] m_mem  [11];
    logic         m_rdy;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box rebuilt from the field inverse and the affine map
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] r;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            m_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        m_rcon[0] = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            m_rcon[k] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    function automatic logic [127:0] model_expand(input logic [127:0] s, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [31:0] last = s[31:0];
        t = {m_sbox[last[23:16]] ^ m_rcon[r], m_sbox[last[15:8]],
             m_sbox[last[7:0]], m_sbox[last[31:24]]};
        w[0] = s[127:96] ^ t;
        w[1] = s[95:64]  ^ w[0];
        w[2] = s[63:32]  ^ w[1];
        w[3] = s[31:0]   ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // One clock cycle: push the expectation for these inputs, advance, compare
    task automatic drive(input logic [2:0] s, input logic [7:0] c);
        exp_t e;
        exp_t got;
        int   ci;
        cs  = s;
        cot = c;
        ci  = int'(c);
        if (m_rdy && ci >= 10 && ci <= 20) begin
            e.rkey = m_mem[20 - ci];
            e.idx  = 4'(20 - ci);
        end else begin
            e.rkey = '0;
            e.idx  = 4'd0;
        end
        if ((s == c_STL || s == c_INV) && ci < 10) begin
            if (ci == 0) m_mem[0] = key_in;
            m_mem[ci + 1] = model_expand((ci == 0) ? key_in : m_mem[ci], ci + 1);
            if (ci == 9) m_rdy = 1'b1;
        end
        e.rdy = m_rdy;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 128'd1, 128'd0);
        end else begin
            got = sbq.pop_front();
            check("rkey", rkey, got.rkey);
            check("rk_idx", {124'd0, rk_idx}, {124'd0, got.idx});
            check("key_rdy", {127'd0, key_rdy}, {127'd0, got.rdy});
        end
    endtask

    task automatic apply_reset();
        res = 1'b1;
        #1;
        check("rst_rkey", rkey, '0);
        check("rst_rk_idx", {124'd0, rk_idx}, '0);
        check("rst_key_rdy", {127'd0, key_rdy}, '0);
        @(posedge clk);
        #1;
        res = 1'b0;
        m_rdy = 1'b0;
        for (int i = 0; i <= 10; i++) m_mem[i] = '0;
    endtask

    task automatic expand(input logic [127:0] k, input int last_cot);
        key_in = k;
        for (int c = 0; c <= last_cot; c++) begin
            drive((c % 2 == 0) ? c_STL : c_INV, 8'(c));
        end
    endtask

    task automatic readout(input logic [127:0] k10, input logic [127:0] k1,
                           input logic [127:0] k0);
        for (int c = 10; c <= 20; c++) begin
            drive(c_ADD, 8'(c));
            if (c == 10) check("key10_const", rkey, k10);
            if (c == 19) check("key1_const", rkey, k1);
            if (c == 20) check("key0_const", rkey, k0);
            drive(c_SUB, 8'(c));
            drive(c_SHI, 8'(c));
        end
        drive(c_FIN, 8'd20);
        drive(c_FIN, 8'd20);
    endtask

    initial begin
        build_tables();
        m_rdy = 1'b0;
        for (int i = 0; i <= 10; i++) m_mem[i] = '0;
        #2;
        apply_reset();

        // Illegal qualifier during pre-roll: nothing stored, never ready
        key_in = c_KEY_A;
        for (int c = 0; c < 10; c++) drive(c_ADD, 8'(c));
        drive(c_ADD, 8'd10);

        // FIPS-197 key: expansion, key_rdy on the cot=9 edge, reverse read-out
        expand(c_KEY_A, 9);
        readout(c_KEY_A10, c_KEY_A1, c_KEY_A);

        // Out-of-range counters after ready
        drive(c_ADD, 8'd21);
        drive(c_ADD, 8'd5);
        drive(c_MIX, 8'd255);
        drive(c_ADD, 8'd9);

        // Non-expansion states with a different key must not disturb the store
        key_in = c_KEY_B;
        for (int c = 0; c < 10; c++) begin
            case (c % 6)
                0: drive(c_ADD, 8'(c));
                1: drive(c_SUB, 8'(c));
                2: drive(c_SHI, 8'(c));
                3: drive(c_MIX, 8'(c));
                4: drive(c_RES, 8'(c));
                default: drive(c_FIN, 8'(c));
            endcase
        end
        readout(c_KEY_A10, c_KEY_A1, c_KEY_A);

        // Second key, fresh from reset
        apply_reset();
        expand(c_KEY_B, 9);
        readout(c_KEY_B10, c_KEY_B1, c_KEY_B);

        // Re-entry without reset, then reset at cot=6 discards everything
        expand(c_KEY_A, 6);
        drive(c_ADD, 8'd10);
        apply_reset();
        drive(c_ADD, 8'd10);
        drive(c_ADD, 8'd20);
        expand(c_KEY_A, 9);
        readout(c_KEY_A10, c_KEY_A1, c_KEY_A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
